multi_lane_block_sync: RTL and testbench
========================================

# multi_lane_block_sync

Parametrised per-lane 64b/66b block synchroniser for the multi-lane PCS receive path. One independent lock engine per lane watches the 2-bit sync header of each block from that lane's RX gearbox. Each engine drives a registered bitslip pulse back to its gearbox until the lane is locked, then supervises lock with a windowed bad-header count. Per-lane lock flags and an aggregate all-lanes-locked flag feed lane deskew and the link state logic.

## Interface
- NUM_LANES, 4, number of independent lanes
- LOCK_COUNT, 64, consecutive-window valid headers required in TEST to declare lock
- TEST_BAD_MAX, 2, bad headers in TEST that abort to LOS
- WINDOW, 64, LOCKED supervision window length in valid blocks
- LOCK_BAD_MAX, 16, bad headers within one WINDOW that drop lock
- SLIP_WAIT, 4, valid blocks ignored after each bitslip (gearbox settle)

- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- sync_bits  in  2*NUM_LANES  lane i header at [2i+1:2i]
- sync_valid  in  NUM_LANES  lane i header qualifies this cycle (gearbox stall when 0)
- bitslip  out  NUM_LANES  one-cycle slip request per lane, registered
- block_locked  out  NUM_LANES  lane in LOCKED, registered
- all_locked  out  1  AND of block_locked, registered

## Operation
- Header good = sync_bits pair is 2'b01 or 2'b10; 00/11 = bad. Only cycles with sync_valid[i]=1 are evaluated; all lane state and counters hold when sync_valid[i]=0.
- Lanes fully independent; no shared counters.
- Per-lane FSM, states LOS, SLIP_HOLD, TEST, LOCKED:
  - LOS: valid good header -> TEST, clear good_cnt/bad_cnt. Valid bad header -> pulse bitslip, load wait_cnt=SLIP_WAIT, -> SLIP_HOLD.
  - SLIP_HOLD: each valid block decrements wait_cnt; the valid block that brings it to 0 -> LOS. Headers ignored. SLIP_WAIT=0 means SLIP_HOLD exits on the first valid block.
  - TEST: each valid block increments good_cnt (good) or bad_cnt (bad). bad_cnt reaching TEST_BAD_MAX -> pulse bitslip, -> SLIP_HOLD (abort has priority). Otherwise good_cnt+bad_cnt reaching LOCK_COUNT -> LOCKED, clear counters.
  - LOCKED: count valid blocks (win_cnt) and bad headers (bad_cnt). bad_cnt reaching LOCK_BAD_MAX -> LOS, no bitslip. win_cnt reaching WINDOW without loss -> clear win_cnt and bad_cnt, stay LOCKED. If the last block of a window is the LOCK_BAD_MAX-th bad header, loss wins.
- Counters sized $clog2(max+1), never wrap; they clear on every state entry.
- Reset mid-operation: all lanes -> LOS immediately, counters clear, outputs 0.

## Timing
- Reset values: bitslip=0, block_locked=0, all_locked=0, all FSMs LOS.
- Decision on valid block at cycle N; state updates at edge N+1; bitslip[i] high for exactly cycle N+1; never two bitslips on one lane closer than SLIP_WAIT+1 valid blocks apart.
- block_locked[i] rises in the cycle after the locking block's edge (same cycle the FSM enters LOCKED, driven from next-state register); it falls the same way on loss.
- all_locked follows the AND of block_locked one cycle later.
- Minimum lock time from clean data after reset: LOCK_COUNT+1 valid blocks.

## Test plan
- Clean alignment, all lanes: 01/10 headers every cycle, valid=1 -> no bitslip; block_locked=4'hF after 65 blocks + 1 cycle; all_locked one cycle later.
- Misaligned lane 2: bad 11 headers on lane 2 only -> bitslip[2] pulses once per 5 valid blocks (SLIP_WAIT=4); other lanes lock; all_locked stays 0; good headers on lane 2 -> lane 2 locks 65 blocks later.
- TEST abort: lane 0 good header, then bad headers at TEST blocks 10 and 20 -> bitslip[0] pulse after block 20, no lock.
- LOCKED supervision: 15 bad headers in one 64-block window -> stays locked; 16th bad in same window -> block_locked[0] drops, no bitslip; 15 bad spread across a window boundary -> stays locked.
- Stalls: sync_valid toggling 1/0 with bad headers on invalid cycles -> identical lock timing counted in valid blocks, bad headers on invalid cycles ignored.
- Async reset asserted while lane 1 LOCKED and lane 3 in SLIP_HOLD -> all outputs 0 immediately; relock from LOS after deassert.

Source files
------------

// File: rtl/multi_lane_block_sync.sv
// Per-lane 64b/66b sync-header lock engines; decisions register one cycle after the valid block, all_locked one later.
// No backpressure: a lane advances only on sync_valid and holds all state on gearbox stalls.
module multi_lane_block_sync #(
   parameter int NUM_LANES    = 4,
   parameter int LOCK_COUNT   = 64,
   parameter int TEST_BAD_MAX = 2,
   parameter int WINDOW       = 64,
   parameter int LOCK_BAD_MAX = 16,
   parameter int SLIP_WAIT    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2*NUM_LANES-1:0] sync_bits,
   input  logic [NUM_LANES-1:0]   sync_valid,
   output logic [NUM_LANES-1:0]   bitslip,
   output logic [NUM_LANES-1:0]   block_locked,
   output logic                   all_locked
);

   localparam logic [1:0] ST_LOS       = 2'd0;
   localparam logic [1:0] ST_SLIP_HOLD = 2'd1;
   localparam logic [1:0] ST_TEST      = 2'd2;
   localparam logic [1:0] ST_LOCKED    = 2'd3;

   localparam int BAD_MAX = (TEST_BAD_MAX > LOCK_BAD_MAX) ? TEST_BAD_MAX : LOCK_BAD_MAX;
   localparam int GW      = $clog2(LOCK_COUNT + 1);
   localparam int BW      = $clog2(BAD_MAX + 1);
   localparam int WNW     = $clog2(WINDOW + 1);
   localparam int SW      = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         logic [1:0]     state, state_nx;
         logic [GW-1:0]  good_cnt, good_nx, good_inc;
         logic [BW-1:0]  bad_cnt, bad_nx, bad_inc;
         logic [WNW-1:0] win_cnt, win_nx, win_inc;
         logic [SW-1:0]  wait_cnt, wait_nx;
         logic           good, slip_nx, slip_q, lock_q;

         assign good     = sync_bits[2*i+1] ^ sync_bits[2*i];
         assign good_inc = good_cnt + GW'(good);
         assign bad_inc  = bad_cnt + BW'(!good);
         assign win_inc  = win_cnt + WNW'(1);

         always_comb begin
            state_nx = state;
            good_nx  = good_cnt;
            bad_nx   = bad_cnt;
            win_nx   = win_cnt;
            wait_nx  = wait_cnt;
            slip_nx  = 1'b0;
            if (sync_valid[i]) begin
               case (state)
                  ST_LOS: begin
                     good_nx = '0;
                     bad_nx  = '0;
                     win_nx  = '0;
                     if (good) begin
                        state_nx = ST_TEST;
                     end else begin
                        state_nx = ST_SLIP_HOLD;
                        slip_nx  = 1'b1;
                        wait_nx  = SW'(SLIP_WAIT);
                     end
                  end
                  ST_SLIP_HOLD: begin
                     // A zero load also exits here, on the first valid block.
                     if (32'(wait_cnt) <= 1) begin
                        state_nx = ST_LOS;
                        wait_nx  = '0;
                     end else begin
                        wait_nx = wait_cnt - SW'(1);
                     end
                  end
                  ST_TEST: begin
                     if (32'(bad_inc) >= TEST_BAD_MAX) begin
                        state_nx = ST_SLIP_HOLD;
                        slip_nx  = 1'b1;
                        wait_nx  = SW'(SLIP_WAIT);
                        good_nx  = '0;
                        bad_nx   = '0;
                     end else if (32'(good_inc) + 32'(bad_inc) >= LOCK_COUNT) begin
                        state_nx = ST_LOCKED;
                        good_nx  = '0;
                        bad_nx   = '0;
                        win_nx   = '0;
                     end else begin
                        good_nx = good_inc;
                        bad_nx  = bad_inc;
                     end
                  end
                  default: begin
                     // Loss is checked before window rollover so the last block of a window can still drop lock.
                     if (32'(bad_inc) >= LOCK_BAD_MAX) begin
                        state_nx = ST_LOS;
                        bad_nx   = '0;
                        win_nx   = '0;
                     end else if (32'(win_inc) >= WINDOW) begin
                        bad_nx = '0;
                        win_nx = '0;
                     end else begin
                        bad_nx = bad_inc;
                        win_nx = win_inc;
                     end
                  end
               endcase
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state    <= ST_LOS;
               good_cnt <= '0;
               bad_cnt  <= '0;
               win_cnt  <= '0;
               wait_cnt <= '0;
               slip_q   <= 1'b0;
               lock_q   <= 1'b0;
            end else begin
               state    <= state_nx;
               good_cnt <= good_nx;
               bad_cnt  <= bad_nx;
               win_cnt  <= win_nx;
               wait_cnt <= wait_nx;
               slip_q   <= slip_nx;
               lock_q   <= (state_nx == ST_LOCKED);
            end
         end

         assign bitslip[i]      = slip_q;
         assign block_locked[i] = lock_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         all_locked <= 1'b0;
      end else begin
         all_locked <= &block_locked;
      end
   end

endmodule

// File: tb/tb_multi_lane_block_sync.sv
// Bench for multi_lane_block_sync: directed block streams, expected output edges queued by cycle and checked by a monitor.
module tb_multi_lane_block_sync;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sync_bits;
   logic [3:0] sync_valid;
   logic [3:0] bitslip;
   logic [3:0] block_locked;
   logic       all_locked;

   always #5 clk = ~clk;

   multi_lane_block_sync #(
      .NUM_LANES(4), .LOCK_COUNT(64), .TEST_BAD_MAX(2),
      .WINDOW(64), .LOCK_BAD_MAX(16), .SLIP_WAIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sync_bits(sync_bits),
      .sync_valid(sync_valid),
      .bitslip(bitslip),
      .block_locked(block_locked),
      .all_locked(all_locked)
   );

   // key = cycle*16 + signal index (0-3 bitslip, 4-7 block_locked, 8 all_locked)
   typedef struct packed {
      int   key;
      logic val;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc      = 0;
   int         n_tests  = 0;
   int         n_fail   = 0;
   logic [3:0] exp_lock = '0;
   logic       exp_all  = 1'b0;
   logic [8:0] prev     = '0;

   localparam logic [7:0] GOOD = 8'b10_01_10_01;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [8:0] cur;
      exp_t       e;
      cur = {all_locked, block_locked, bitslip};
      for (int k = 0; k < 9; k++) begin
         if (cur[k] !== prev[k]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_edge sig=%0d cyc=%0d: got %b, required no change", k, cyc, cur[k]);
            end else begin
               e = exp_q.pop_front();
               if (e.key != cyc * 16 + k || e.val !== cur[k]) begin
                  n_fail++;
                  $display("FAIL edge sig=%0d cyc=%0d val=%b, required sig=%0d cyc=%0d val=%b",
                           k, cyc, cur[k], e.key % 16, e.key / 16, e.val);
               end
            end
         end
      end
      prev = cur;
   end

   function automatic logic [7:0] mk(input logic [1:0] h0, input logic [1:0] h1,
                                     input logic [1:0] h2, input logic [1:0] h3);
      return {h3, h2, h1, h0};
   endfunction

   task automatic push_exp(input int c, input int k, input logic v);
      exp_t e;
      int   idx;
      e.key = c * 16 + k;
      e.val = v;
      idx   = 0;
      while (idx < exp_q.size() && exp_q[idx].key <= e.key) idx++;
      exp_q.insert(idx, e);
   endtask

   task automatic step(input logic [7:0] bits, input logic [3:0] vld);
      @(posedge clk);
      #1;
      sync_bits  = bits;
      sync_valid = vld;
   endtask

   task automatic expect_slip(input int l);
      push_exp(cyc + 1, l, 1'b1);
      push_exp(cyc + 2, l, 1'b0);
   endtask

   task automatic expect_lock(input int l, input logic v);
      if (exp_lock[l] != v) push_exp(cyc + 1, 4 + l, v);
      exp_lock[l] = v;
      if ((&exp_lock) != exp_all) push_exp(cyc + 2, 8, &exp_lock);
      exp_all = &exp_lock;
   endtask

   task automatic check_zero(input string name);
      n_tests++;
      if ({bitslip, block_locked, all_locked} !== 9'b0) begin
         n_fail++;
         $display("FAIL %s: outputs bitslip=%b locked=%b all=%b, required all zero",
                  name, bitslip, block_locked, all_locked);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset      = 1'b1;
      sync_valid = '0;
      for (int l = 0; l < 4; l++) if (exp_lock[l]) push_exp(cyc, 4 + l, 1'b0);
      if (exp_all) push_exp(cyc, 8, 1'b0);
      exp_lock = '0;
      exp_all  = 1'b0;
      #1;
      check_zero("async_reset");
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic is_bad0(input int b);
      return (b >= 70 && b <= 84) || (b >= 186 && b <= 200) ||
             (b >= 260 && b <= 275) || (b >= 389 && b <= 404);
   endfunction

   initial begin
      reset      = 1'b0;
      sync_bits  = '0;
      sync_valid = '0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;

      // Clean alignment: lock on block 65.
      for (int b = 1; b <= 70; b++) begin
         step(GOOD, 4'hF);
         if (b == 65) for (int l = 0; l < 4; l++) expect_lock(l, 1'b1);
      end
      do_reset();

      // Lane 2 misaligned for 70 blocks, then clean.
      for (int b = 1; b <= 140; b++) begin
         step(mk(2'b01, 2'b10, (b <= 70) ? 2'b11 : 2'b01, 2'b10), 4'hF);
         if (b <= 70 && b % 5 == 1) expect_slip(2);
         if (b == 65) begin
            expect_lock(0, 1'b1);
            expect_lock(1, 1'b1);
            expect_lock(3, 1'b1);
         end
         if (b == 135) expect_lock(2, 1'b1);
      end
      do_reset();

      // TEST abort on lane 0: bad at TEST blocks 10 and 20.
      for (int b = 1; b <= 95; b++) begin
         step(mk((b == 11 || b == 21) ? 2'b00 : 2'b01, 2'b10, 2'b01, 2'b10), 4'hF);
         if (b == 21) expect_slip(0);
         if (b == 65) begin
            expect_lock(1, 1'b1);
            expect_lock(2, 1'b1);
            expect_lock(3, 1'b1);
         end
         if (b == 90) expect_lock(0, 1'b1);
      end
      do_reset();

      // LOCKED supervision on lane 0; windows start at blocks 66, 130, 194, 258.
      for (int b = 1; b <= 475; b++) begin
         step(mk(is_bad0(b) ? 2'b00 : 2'b01, 2'b10, 2'b01, 2'b10), 4'hF);
         if (b == 65) for (int l = 0; l < 4; l++) expect_lock(l, 1'b1);
         if (b == 275 || b == 404) expect_lock(0, 1'b0);
         if (b == 340 || b == 469) expect_lock(0, 1'b1);
      end
      do_reset();

      // Stalls: valid on odd steps, bad headers on stalled steps.
      for (int s = 1; s <= 135; s++) begin
         if (s % 2 == 1) step(GOOD, 4'hF);
         else            step(8'hFF, 4'h0);
         if (s == 129) for (int l = 0; l < 4; l++) expect_lock(l, 1'b1);
      end
      do_reset();

      // Lanes 0-2 locked, lane 3 slipping; reset lands with lane 3 in SLIP_HOLD.
      for (int b = 1; b <= 68; b++) begin
         step(mk(2'b01, 2'b10, 2'b01, 2'b11), 4'hF);
         if (b % 5 == 1) expect_slip(3);
         if (b == 65) for (int l = 0; l < 3; l++) expect_lock(l, 1'b1);
      end
      do_reset();
      for (int b = 1; b <= 70; b++) begin
         step(GOOD, 4'hF);
         if (b == 65) for (int l = 0; l < 4; l++) expect_lock(l, 1'b1);
      end

      repeat (5) step(GOOD, 4'h0);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_events: %0d expected edges never seen, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
